video_timing_pattern_gen: RTL and testbench
===========================================

// Module: video_timing_pattern_gen
// PURPOSE
//  Generates raster timing (hsync, vsync, data-enable) and a selectable test-pattern pixel
//  stream for the HDMI/DVI output path. Sits directly upstream of the three per-channel
//  TMDS encoders: r/g/b feed din, hs/vs feed c0/c1 of the blue channel, de feeds de.
//  All outputs are registered in the pixel clock domain; no handshake, free-running raster.
// PARAMETERS
//  H_ACTIVE  1280  active pixels per line (must be a multiple of 8)
//  H_FP      110   horizontal front porch, pixels
//  H_SYNC    40    horizontal sync width, pixels
//  H_BP      220   horizontal back porch, pixels
//  V_ACTIVE  720   active lines per frame
//  V_FP      5     vertical front porch, lines
//  V_SYNC    5     vertical sync width, lines
//  V_BP      20    vertical back porch, lines
//  HS_POL    1     hs level during sync (1 = positive)
//  VS_POL    1     vs level during sync (1 = positive)
// PORTS
//  clkin        in   1   pixel clock
//  rstin        in   1   synchronous reset, active high
//  pat_sel      in   2   00 colour bars, 01 ramp, 10 solid, 11 checkerboard
//  solid_rgb    in   24  {R,G,B} used when pat_sel=10
//  hs           out  1   horizontal sync
//  vs           out  1   vertical sync
//  de           out  1   data enable (active video)
//  r, g, b      out  8   pixel components, valid when de=1, else 0
//  pix_x        out  12  active x coordinate, aligned with de (0 when de=0)
//  pix_y        out  12  active y coordinate, aligned with de (0 when de=0)
//  frame_start  out  1   one-cycle pulse coincident with pixel (0,0) on outputs
// BEHAVIOUR
//  - Counters h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1; H_TOTAL=sum of H_*, V_TOTAL=sum of V_*.
//    h_cnt wraps to 0 at H_TOTAL-1; v_cnt increments only on h_cnt wrap, wraps at V_TOTAL-1.
//  - Line/frame order: active, front porch, sync, back porch. h_cnt=0,v_cnt=0 = first pixel.
//  - Decode: de=(h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE);
//    hs sync when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC;
//    vs sync when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (changes only at h_cnt=0).
//  - Latency: every output registers the decode of the counter state one cycle earlier;
//    hs/vs/de/r/g/b/pix_x/pix_y/frame_start are mutually cycle-aligned.
//  - Reset (rstin=1 at an edge): counters=0, hs=~HS_POL, vs=~VS_POL, de=0, r=g=b=0,
//    pix_x=pix_y=0, frame_start=0, active pattern=00. Reset mid-frame abandons the frame;
//    first edge with rstin=0 outputs pixel (0,0) with de=1 and frame_start=1.
//  - pat_sel is captured only when counters are at (0,0); changes mid-frame take effect
//    next frame (no tearing). solid_rgb is sampled every pixel.
//  - Colour bars: 8 bars of H_ACTIVE/8 pixels, order white, yellow, cyan, green, magenta,
//    red, blue, black (components 8'hFF/8'h00); bar index from a per-line bar counter,
//    no divider. Ramp: r=g=b=pix_x[7:0] (wraps every 256). Checkerboard: white when
//    pix_x[5]^pix_y[5]=0, else black.
//  - Outside active video r/g/b/pix_x/pix_y are forced to 0 regardless of pattern.
// TESTING
//  Small params (H 16/2/3/3 -> H_TOTAL 24, V 4/1/2/1 -> V_TOTAL 8) unless noted.
//  1 Release reset -> de high 16 cycles, low 8; hs sync for cycles 18..20 of each line;
//    frame period exactly 192 cycles; frame_start once per 192.
//  2 vs: asserted for lines 5..6 (48 cycles), edges coincide with hs-line boundary h_cnt=0.
//  3 pat_sel=00 -> per line pixel pairs: FFFFFF,FFFF00,00FFFF,00FF00,FF00FF,FF0000,0000FF,000000.
//  4 Change pat_sel 00->01 mid-frame -> bars continue to frame end; next frame r=g=b=pix_x.
//  5 Assert rstin for 1 cycle mid-line -> outputs idle that cycle, next cycle pixel (0,0)
//    with frame_start=1; pat_sel reset value 00 until next (0,0) capture.
//  6 Default 720p params -> H_TOTAL 1650, V_TOTAL 750, 921600 de cycles per frame; pol checks.

Source files
------------

// File: rtl/video_timing_pattern_gen.sv
// Raster timing generator (hs/vs/de) with a selectable test-pattern pixel stream.
// All outputs register the decode of the h/v counter state present at the same edge.
module video_timing_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        clkin,
    input  logic        rstin,
    input  logic [1:0]  pat_sel,
    input  logic [23:0] solid_rgb,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

    logic [11:0] h_cnt, v_cnt;
    logic [11:0] bar_cnt;
    logic [2:0]  bar_idx;
    logic [1:0]  pat_q;

    logic        h_wrap, v_wrap, at_origin;
    logic [1:0]  pat_eff;
    logic        act, in_hs, in_vs;
    logic [7:0]  nr, ng, nb;

    assign h_wrap    = (h_cnt == H_LAST);
    assign v_wrap    = (v_cnt == V_LAST);
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    // The pattern captured at (0,0) already applies to pixel (0,0), so a frame never mixes patterns.
    assign pat_eff   = at_origin ? pat_sel : pat_q;

    always_comb begin
        act   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        in_hs = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        in_vs = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        nr = '0;
        ng = '0;
        nb = '0;
        if (act) begin
            case (pat_eff)
                // bar order white,yellow,cyan,green,magenta,red,blue,black maps to inverted index bits
                2'b00: begin
                    nr = {8{~bar_idx[1]}};
                    ng = {8{~bar_idx[2]}};
                    nb = {8{~bar_idx[0]}};
                end
                2'b01: begin
                    nr = h_cnt[7:0];
                    ng = h_cnt[7:0];
                    nb = h_cnt[7:0];
                end
                2'b10: {nr, ng, nb} = solid_rgb;
                default: {nr, ng, nb} = (h_cnt[5] ^ v_cnt[5]) ? 24'h000000 : 24'hFFFFFF;
            endcase
        end
    end

    always_ff @(posedge clkin) begin
        if (rstin) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            bar_cnt     <= '0;
            bar_idx     <= '0;
            pat_q       <= 2'b00;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end

            // bar counter tracks h_cnt so the bar index needs no divider
            if (h_wrap) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (h_cnt < H_ACT) begin
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt + 12'd1;
                end
            end

            pat_q       <= pat_eff;
            hs          <= in_hs ? HS_POL : ~HS_POL;
            vs          <= in_vs ? VS_POL : ~VS_POL;
            de          <= act;
            r           <= nr;
            g           <= ng;
            b           <= nb;
            pix_x       <= act ? h_cnt : '0;
            pix_y       <= act ? v_cnt : '0;
            frame_start <= at_origin;
        end
    end
endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Bench: two raster generators (small timing, and 720p timing with negative sync polarity)
// compared every cycle against a position-from-cycle-count reference model.
module tb_video_timing_pattern_gen;
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
    } px_t;

    localparam int NCYC = 6000;

    logic        clkin = 1'b0;
    logic        rstin;
    logic [1:0]  pat_sel;
    logic [23:0] solid_rgb;

    logic        a_hs, a_vs, a_de, a_fs;
    logic [7:0]  a_r, a_g, a_b;
    logic [11:0] a_x, a_y;
    logic        b_hs, b_vs, b_de, b_fs;
    logic [7:0]  b_r, b_g, b_b;
    logic [11:0] b_x, b_y;

    px_t qa[$];
    px_t qb[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    always #5 clkin = ~clkin;

    video_timing_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_a (
        .clkin(clkin), .rstin(rstin), .pat_sel(pat_sel), .solid_rgb(solid_rgb),
        .hs(a_hs), .vs(a_vs), .de(a_de), .r(a_r), .g(a_g), .b(a_b),
        .pix_x(a_x), .pix_y(a_y), .frame_start(a_fs)
    );

    video_timing_pattern_gen #(
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_b (
        .clkin(clkin), .rstin(rstin), .pat_sel(pat_sel), .solid_rgb(solid_rgb),
        .hs(b_hs), .vs(b_vs), .de(b_de), .r(b_r), .g(b_g), .b(b_b),
        .pix_x(b_x), .pix_y(b_y), .frame_start(b_fs)
    );

    // Reference: pixel at cycle t after reset release, from plain raster arithmetic.
    function automatic px_t model(input int t, input logic [1:0] pat, input logic [23:0] solid,
                                  input int ha, input int hf, input int hsw, input int hb,
                                  input int va, input int vf, input int vsw, input int vb,
                                  input bit hp, input bit vp);
        logic [23:0] bars [8];
        int ht, vt, h, v;
        px_t e;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        h  = t % ht;
        v  = (t / ht) % vt;
        e  = '0;
        e.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
        e.vs = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
        e.de = (h < ha) && (v < va);
        e.fs = (h == 0) && (v == 0);
        if (e.de) begin
            e.x = 12'(h);
            e.y = 12'(v);
            case (pat)
                2'd0: {e.r, e.g, e.b} = bars[h / (ha / 8)];
                2'd1: begin
                    e.r = 8'(h % 256);
                    e.g = 8'(h % 256);
                    e.b = 8'(h % 256);
                end
                2'd2: {e.r, e.g, e.b} = solid;
                default: {e.r, e.g, e.b} = (((h / 32) % 2) != ((v / 32) % 2)) ? 24'h000000 : 24'hFFFFFF;
            endcase
        end
        return e;
    endfunction

    function automatic px_t idle(input bit hp, input bit vp);
        px_t e;
        e    = '0;
        e.hs = !hp;
        e.vs = !vp;
        return e;
    endfunction

    task automatic check(input string name, input px_t got, input px_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, exp);
    endtask

    // monitor: one registered pixel per cycle on each DUT
    initial begin
        forever begin
            @(posedge clkin);
            #1;
            if (qa.size() == 0 || qb.size() == 0) begin
                n_chk++;
                $display("FAIL scoreboard_empty t=%0t got=%0d want=1", $time, qa.size());
            end else begin
                check("dut_a_pixel", {a_hs, a_vs, a_de, a_r, a_g, a_b, a_x, a_y, a_fs}, qa.pop_front());
                check("dut_b_pixel", {b_hs, b_vs, b_de, b_r, b_g, b_b, b_x, b_y, b_fs}, qb.pop_front());
            end
        end
    end

    // driver: sets inputs between edges and pushes the expectation for the next edge
    initial begin
        int t = 0;
        logic [1:0] mpa = 2'b00;
        logic [1:0] mpb = 2'b00;
        logic [1:0] pat = 2'b00;
        logic rst;
        for (int c = 0; c < NCYC; c++) begin
            rst = (c < 3) || (c == 1000) || (c == 1203) || ($urandom_range(0, 799) == 0);
            if (c >= 200 && $urandom_range(0, 39) == 0) pat = 2'($urandom_range(0, 3));
            rstin     = rst;
            pat_sel   = pat;
            solid_rgb = 24'($urandom);
            if (rst) begin
                t   = 0;
                mpa = 2'b00;
                mpb = 2'b00;
                qa.push_back(idle(1'b1, 1'b1));
                qb.push_back(idle(1'b0, 1'b0));
            end else begin
                if (t % (24 * 8) == 0)     mpa = pat;
                if (t % (1650 * 750) == 0) mpb = pat;
                qa.push_back(model(t, mpa, solid_rgb, 16, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1));
                qb.push_back(model(t, mpb, solid_rgb, 1280, 110, 40, 220, 720, 5, 5, 20, 1'b0, 1'b0));
                t++;
            end
            @(negedge clkin);
        end
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
